// File: rtl/boid_xcel_pkg.sv
// Shared types and helpers for the boid accelerator sequencer.
//   ctrl_state_t  - sequencer states
//   N_BOIDS_DEF   - default boids per frame
//   WB_STAGES_DEF - default writeback settle cycles (width of wb_en)
//   wb_therm(k)   - thermometer mask with bits 0..k set
package boid_xcel_pkg;

    localparam int unsigned N_BOIDS_DEF   = 64;
    localparam int unsigned WB_STAGES_DEF = 7;
    localparam int unsigned THERM_W       = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITR,
        S_DRAIN,
        S_WB,
        S_WRITE,
        S_DONE
    } ctrl_state_t;

    // Bit b is set for every b <= k, so bit 0 rises first as k counts up.
    function automatic logic [THERM_W-1:0] wb_therm(input int unsigned k);
        logic [THERM_W-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < THERM_W; b++) begin
            m[b] = (b <= k);
        end
        return m;
    endfunction

endpackage

// File: rtl/boid_idx_ctr.sv
// Loadable, clearable up-counter with terminal-count flag.
//   clk, rst_n   - clock, synchronous active-low reset
//   clr          - force count to 0 (highest priority)
//   ld, ld_val   - load a value
//   inc          - increment by one
//   cnt          - current count
//   tc           - count equals MAX
module boid_idx_ctr #(
    parameter int unsigned W   = 6,
    parameter int unsigned MAX = 63
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next-count select: clear, then load, then increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (ld) begin
            cnt_d = ld_val;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == W'(MAX));

endmodule

// File: rtl/d_reg.sv
// Plain D flop with synchronous active-low reset to zero.
//   clk, reset (0 = reset), d -> q one cycle later
module d_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/boid_xcel_ctrl.sv
// Sequencer for the boid accelerator datapath. Per boid i: load i, stream
// all boids past it, let writeback settle, write i back in place.
//   clk, reset        - clock, synchronous active-low reset
//   start             - frame request, sampled only in IDLE
//   busy, done        - frame in progress / one-cycle completion pulse
//   rd_addr           - boid memory read address (data 1 cycle later)
//   wr_en, wr_addr    - boid memory write strobe and address
//   r_en_tot          - datapath: latch boid i, clear accumulators
//   r_en_itr          - datapath: accumulate current read data
//   wb_en             - datapath writeback enable, thermometer-coded
//   cur_idx           - current boid index i
module boid_xcel_ctrl
    import boid_xcel_pkg::*;
#(
    parameter int unsigned N_BOIDS   = N_BOIDS_DEF,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned WB_STAGES = WB_STAGES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 r_en_tot,
    output logic                 r_en_itr,
    output logic [WB_STAGES-1:0] wb_en,
    output logic [ADDR_W-1:0]    cur_idx
);

    localparam int unsigned K_W = (WB_STAGES > 1) ? $clog2(WB_STAGES) : 1;

    ctrl_state_t state_q;
    ctrl_state_t state_d;

    logic [ADDR_W-1:0] i_q;
    logic [ADDR_W-1:0] j_q;
    logic [K_W-1:0]    k_q;
    logic              i_tc;
    logic              j_tc;
    logic              k_tc;
    logic              i_clr;
    logic              i_inc;
    logic              j_clr;
    logic              j_inc;
    logic              k_clr;
    logic              k_inc;

    logic              tot_d;
    logic              tot_q;
    logic              itr_d;
    logic              itr_q;
    logic [ADDR_W-1:0] jq_d;
    logic [ADDR_W-1:0] jq_q;

    // Boid index i, stream index j, writeback stage k.
    boid_idx_ctr #(.W(ADDR_W), .MAX(N_BOIDS - 1)) u_i_ctr (
        .clk    (clk),
        .rst_n  (reset),
        .clr    (i_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (i_inc),
        .cnt    (i_q),
        .tc     (i_tc)
    );

    boid_idx_ctr #(.W(ADDR_W), .MAX(N_BOIDS - 1)) u_j_ctr (
        .clk    (clk),
        .rst_n  (reset),
        .clr    (j_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (j_inc),
        .cnt    (j_q),
        .tc     (j_tc)
    );

    boid_idx_ctr #(.W(K_W), .MAX(WB_STAGES - 1)) u_k_ctr (
        .clk    (clk),
        .rst_n  (reset),
        .clr    (k_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (k_inc),
        .cnt    (k_q),
        .tc     (k_tc)
    );

    // Read-data alignment flags: enables land with the data, one cycle after the address.
    d_reg #(.W(1))      u_tot_reg (.clk(clk), .reset(reset), .d(tot_d), .q(tot_q));
    d_reg #(.W(1))      u_itr_reg (.clk(clk), .reset(reset), .d(itr_d), .q(itr_q));
    d_reg #(.W(ADDR_W)) u_jq_reg  (.clk(clk), .reset(reset), .d(jq_d),  .q(jq_q));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, counter control and output decode from registered state.
    always_comb begin
        state_d = state_q;
        i_clr   = 1'b0;
        i_inc   = 1'b0;
        j_clr   = 1'b0;
        j_inc   = 1'b0;
        k_clr   = 1'b0;
        k_inc   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wb_en   = '0;
        tot_d   = (state_q == S_LOAD);
        itr_d   = (state_q == S_ITR);
        jq_d    = j_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    i_clr   = 1'b1;
                    j_clr   = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                rd_addr = i_q;
                j_clr   = 1'b1;
                state_d = S_ITR;
            end
            S_ITR: begin
                busy    = 1'b1;
                rd_addr = j_q;
                if (j_tc) begin
                    state_d = S_DRAIN;
                end else begin
                    j_inc = 1'b1;
                end
            end
            S_DRAIN: begin
                // j holds at its last value, so the address does too.
                busy    = 1'b1;
                rd_addr = j_q;
                k_clr   = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                busy  = 1'b1;
                wb_en = WB_STAGES'(wb_therm(32'(k_q)));
                if (k_tc) begin
                    state_d = S_WRITE;
                end else begin
                    k_inc = 1'b1;
                end
            end
            S_WRITE: begin
                busy    = 1'b1;
                wb_en   = '1;
                wr_en   = 1'b1;
                wr_addr = i_q;
                if (i_tc) begin
                    state_d = S_DONE;
                end else begin
                    i_inc   = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                i_clr   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign r_en_tot = tot_q;
    assign r_en_itr = itr_q && (jq_q != i_q);
    assign cur_idx  = i_q;

endmodule

// File: tb/tb_boid_xcel_ctrl.sv
// Directed bench for boid_xcel_ctrl with N_BOIDS=4, WB_STAGES=7.
module tb_boid_xcel_ctrl;

    localparam int unsigned NB     = 4;
    localparam int unsigned AW     = 2;
    localparam int unsigned WS     = 7;
    localparam int           NCYC  = 200;

    logic          clk;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          r_en_tot;
    logic          r_en_itr;
    logic [WS-1:0] wb_en;
    logic [AW-1:0] cur_idx;

    int n_chk;
    int n_pass;

    logic          a_busy [0:NCYC-1];
    logic          a_done [0:NCYC-1];
    logic          a_tot  [0:NCYC-1];
    logic          a_itr  [0:NCYC-1];
    logic          a_wr   [0:NCYC-1];
    logic [AW-1:0] a_wa   [0:NCYC-1];
    logic [WS-1:0] a_wb   [0:NCYC-1];

    boid_xcel_ctrl #(.N_BOIDS(NB), .ADDR_W(AW), .WB_STAGES(WS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .r_en_tot (r_en_tot),
        .r_en_itr (r_en_itr),
        .wb_en    (wb_en),
        .cur_idx  (cur_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected outputs for cycle t of the scripted run:
    // frames accepted at 0, 58 (killed by reset at 78) and 150.
    // Packing: {busy, done, rd_addr, wr_en, wr_addr, r_en_tot, r_en_itr, wb_en}.
    function automatic logic [15:0] model(input int t, output logic [1:0] ci, output bit ci_ok);
        int s;
        int o;
        int b;
        int p;
        logic          e_busy;
        logic          e_done;
        logic [1:0]    e_rd;
        logic          e_wr;
        logic [1:0]    e_wa;
        logic          e_tot;
        logic          e_itr;
        logic [6:0]    e_wb;
        e_busy = 0; e_done = 0; e_rd = 0; e_wr = 0; e_wa = 0;
        e_tot = 0; e_itr = 0; e_wb = 0; ci = 0; ci_ok = 1;
        s = -1;
        if (t >= 150)                 s = 150;
        else if (t >= 58 && t <= 78)  s = 58;
        else if (t < 58)              s = 0;
        if (s >= 0) begin
            o = t - s;
            if (o >= 1 && o <= 56) begin
                b = (o - 1) / 14;
                p = (o - 1) % 14;
                e_busy = 1;
                ci     = 2'(b);
                if (p == 0)              e_rd = 2'(b);
                if (p >= 1 && p <= 4)    e_rd = 2'(p - 1);
                if (p == 5)              e_rd = 2'd3;
                e_tot = (p == 1);
                e_itr = (p >= 2 && p <= 5) && ((p - 2) != b);
                if (p >= 6 && p <= 12)   e_wb = 7'((1 << (p - 5)) - 1);
                if (p == 13) begin
                    e_wb = 7'h7F;
                    e_wr = 1;
                    e_wa = 2'(b);
                end
            end else if (o == 57) begin
                e_done = 1;
                ci_ok  = 0;
            end
        end
        return {e_busy, e_done, e_rd, e_wr, e_wa, e_tot, e_itr, e_wb};
    endfunction

    initial begin
        logic [15:0] exp_v;
        logic [15:0] got_v;
        logic [1:0]  exp_ci;
        bit          ci_ok;
        int          cnt;
        logic [6:0]  wb_tab [0:6];

        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b0;
        start  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_outs",  32'({done, rd_addr, wr_en, wr_addr, r_en_tot, r_en_itr, wb_en, cur_idx}), 32'd0);
        reset = 1'b1;

        // Scripted run; cycle t outputs sampled mid-cycle, inputs for cycle t set alongside.
        for (int t = 0; t < NCYC; t++) begin
            @(negedge clk);
            got_v = {busy, done, rd_addr, wr_en, wr_addr, r_en_tot, r_en_itr, wb_en};
            exp_v = model(t, exp_ci, ci_ok);
            check($sformatf("cyc%0d_outs", t), 32'(got_v), 32'(exp_v));
            if (ci_ok) check($sformatf("cyc%0d_cur_idx", t), 32'(cur_idx), 32'(exp_ci));
            if (r_en_tot && r_en_itr) check($sformatf("cyc%0d_tot_itr_excl", t), 32'd1, 32'd0);
            if (wr_en) check($sformatf("cyc%0d_wr_wb_full", t), 32'(wb_en), 32'h7F);
            a_busy[t] = busy;
            a_done[t] = done;
            a_tot[t]  = r_en_tot;
            a_itr[t]  = r_en_itr;
            a_wr[t]   = wr_en;
            a_wa[t]   = wr_addr;
            a_wb[t]   = wb_en;
            start = (t == 0 || t == 10 || t == 57 || t == 58 || t == 150);
            reset = (t != 78);
        end
        start = 1'b0;
        reset = 1'b1;

        // Single-frame timing
        check("tot_at_2",    32'(a_tot[2]), 32'd1);
        check("itr_at_3",    32'(a_itr[3]), 32'd0);
        check("itr_at_4",    32'(a_itr[4]), 32'd1);
        check("itr_at_5",    32'(a_itr[5]), 32'd1);
        check("itr_at_6",    32'(a_itr[6]), 32'd1);
        wb_tab[0] = 7'h01; wb_tab[1] = 7'h03; wb_tab[2] = 7'h07; wb_tab[3] = 7'h0F;
        wb_tab[4] = 7'h1F; wb_tab[5] = 7'h3F; wb_tab[6] = 7'h7F;
        for (int c = 0; c < 7; c++) begin
            check($sformatf("wb_at_%0d", 7 + c), 32'(a_wb[7 + c]), 32'(wb_tab[c]));
        end
        check("wr_at_14",    32'({a_wr[14], a_wa[14]}), 32'({1'b1, 2'd0}));
        check("tot_at_16",   32'(a_tot[16]), 32'd1);

        // Self-exclusion for i=2 (LOAD at 29, jq=2 at 33)
        check("i2_itr_31",   32'(a_itr[31]), 32'd1);
        check("i2_itr_32",   32'(a_itr[32]), 32'd1);
        check("i2_itr_33",   32'(a_itr[33]), 32'd0);
        check("i2_itr_34",   32'(a_itr[34]), 32'd1);
        cnt = 0;
        for (int c = 0; c <= 57; c++) cnt += int'(a_itr[c]);
        check("itr_pulses_frame", 32'(cnt), 32'd12);

        // Frame completion
        cnt = 0;
        for (int c = 0; c <= 57; c++) cnt += int'(a_wr[c]);
        check("wr_pulses_frame", 32'(cnt), 32'd4);
        check("wr_addr_28",  32'({a_wr[28], a_wa[28]}), 32'({1'b1, 2'd1}));
        check("wr_addr_42",  32'({a_wr[42], a_wa[42]}), 32'({1'b1, 2'd2}));
        check("wr_addr_56",  32'({a_wr[56], a_wa[56]}), 32'({1'b1, 2'd3}));
        check("done_at_57",  32'(a_done[57]), 32'd1);
        cnt = 0;
        for (int c = 1; c <= 56; c++) cnt += int'(a_busy[c]);
        check("busy_cycles", 32'(cnt), 32'd56);
        check("busy_at_57",  32'(a_busy[57]), 32'd0);

        // Start while busy / in DONE ignored; start at 58 gives LOAD at 59
        cnt = 0;
        for (int c = 0; c < NCYC; c++) cnt += int'(a_done[c]);
        check("done_total",  32'(cnt), 32'd1);
        check("busy_at_58",  32'(a_busy[58]), 32'd0);
        check("busy_at_59",  32'(a_busy[59]), 32'd1);
        check("tot_at_60",   32'(a_tot[60]), 32'd1);

        // Reset mid-frame at 78: nothing afterwards until the new start
        cnt = 0;
        for (int c = 79; c <= 150; c++) cnt += int'(a_wr[c]) + int'(a_done[c]) + int'(a_busy[c]);
        check("post_reset_quiet", 32'(cnt), 32'd0);
        check("restart_busy_151", 32'(a_busy[151]), 32'd1);
        check("restart_tot_152",  32'(a_tot[152]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/boid_xcel_ctrl.md
# boid_xcel_ctrl

Sequencer for the boid accelerator datapath. For each boid `i` in boid memory it:

- loads boid `i` into the datapath;
- streams every other boid past it for the neighbour/separation accumulation;
- gives the combinational writeback path a fixed settle window;
- writes the updated boid `i` back in place.

It sits between the M10K boid memory (1-cycle registered read) and the datapath control inputs `r_en_tot`, `r_en_itr` and `wb_en`. A frame runs from a `start` pulse, and completion is reported with a `done` pulse.

## Interface

Parameters:
- N_BOIDS, 64: boids per frame; must be ≥2 and a power of two.
- ADDR_W, 6: memory address width, equal to log2(N_BOIDS).
- WB_STAGES, 7: writeback settle cycles, equal to the width of `wb_en`.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- start  in  1  frame request; sampled only in IDLE
- busy  out  1  high from the cycle after `start` is accepted until `done`
- done  out  1  one-cycle pulse when the frame completes
- rd_addr  out  ADDR_W  boid memory read address; data returns 1 cycle later
- wr_en  out  1  boid memory write strobe
- wr_addr  out  ADDR_W  write address (always `i`)
- r_en_tot  out  1  datapath: latch boid `i`, clear accumulators
- r_en_itr  out  1  datapath: accumulate the current read data
- wb_en  out  WB_STAGES  datapath writeback enable, thermometer-coded
- cur_idx  out  ADDR_W  current boid index `i` (debug/status)

## Operation

States: IDLE, LOAD, ITR, DRAIN, WB, WRITE, DONE.

- **IDLE:** all outputs 0. On `start`=1, clear `i` and `j` and go to LOAD.
- **LOAD (1 cycle):** `rd_addr`=`i`; set `tot_q`. Go to ITR with `j`=0.
- **ITR (N_BOIDS cycles):** `rd_addr`=`j`, and `j` increments each cycle. Leave when `j`=N_BOIDS-1 and go to DRAIN.
- **DRAIN (1 cycle):** receives the final read data. `rd_addr` holds its last value.
- **WB (WB_STAGES cycles):** counter `k` runs 0..WB_STAGES-1; `wb_en` = (2^(k+1))-1, so bit 0 rises first. Go to WRITE.
- **WRITE (1 cycle):**
  - `wb_en` = all ones, `wr_en`=1, `wr_addr`=`i`.
  - If `i`=N_BOIDS-1, go to DONE.
  - Otherwise increment `i` and go to LOAD.
- **DONE (1 cycle):** `done`=1, `busy`=0. Go to IDLE.

Read-data alignment uses registered flags:
- `tot_q` = registered (state==LOAD).
- `itr_q` = registered (state==ITR).
- `jq` = registered `j`.
- `r_en_tot` = `tot_q`.
- `r_en_itr` = `itr_q` && (`jq` != `i`). Boid `i` is never accumulated against itself.

Other rules:
- `start` outside IDLE is ignored, not queued.
- `r_en_tot` and `r_en_itr` are never high in the same cycle.
- `wr_en` is high only in WRITE.
- Writes are in place, so boids after `i` see the already-updated boid `i`. This is intended.
- `i` and `j` use wrap-free compares against N_BOIDS-1; no counter ever wraps during a frame.
- Cycles per boid = N_BOIDS + WB_STAGES + 3. A frame takes N_BOIDS·(N_BOIDS+WB_STAGES+3) + 1 cycles from start acceptance to `done`.

## Timing

- **Reset:** on any edge with `reset`=0, state=IDLE, `i`=`j`=`k`=0, and every output is 0. This holds mid-frame too: a partially processed frame is abandoned, with no write and no `done`.
- **Cycle numbering:** the cycle `start` is sampled is 0, so LOAD is cycle 1. All outputs are registered or decoded from registered state; there is no combinational path from `start` to outputs.
- **Read alignment:** the read address issued in cycle t has data valid, with the matching enable, in cycle t+1.
- **`busy`:** rises with LOAD and falls in DONE.
- **`done` with a new `start`:** a `start` arriving in the DONE cycle is ignored. It is accepted the next cycle, in IDLE.

## Structure

- Shared package `boid_xcel_pkg` holds:
  - `ctrl_state_t` enum (the seven states);
  - `N_BOIDS_DEF`, `WB_STAGES_DEF`;
  - a function `wb_therm(k)` that produces the thermometer mask.
- There is one natural sub-module, `boid_idx_ctr`: a loadable, clearable up-counter with a terminal-count flag. It is instantiated three times, for `i`, `j` and `k`.
- Flag registers use the existing `d_reg`.

## Test plan

All scenarios use N_BOIDS=4, WB_STAGES=7.

1. **Single frame:** `start` in cycle 0 -> `r_en_tot` at cycle 2; `r_en_itr` at cycles 4, 5, 6 (not 3); `wb_en` 1, 3, …, 127 over cycles 7–13; `wr_en` with `wr_addr`=0 at cycle 14; LOAD for `i`=1 at cycle 15.
2. **Self-exclusion:** for `i`=2, `r_en_itr` is low exactly in the cycle `jq`=2, so three `r_en_itr` pulses occur per boid for every `i`.
3. **Frame completion:** exactly four `wr_en` pulses, at addresses 0, 1, 2, 3; `done` high only at cycle 57; `busy` high over cycles 1–56.
4. **Start while busy:** `start` pulses at cycles 10 and 57 -> no effect, `done` count = 1; a `start` at cycle 58 begins a new frame with LOAD at cycle 59.
5. **Reset mid-frame:** `reset`=0 at cycle 20 -> at cycle 21 all outputs are 0 and state is IDLE; no further `wr_en` or `done` until a new `start`.
6. **Mutual exclusion assertions**, checked over a full frame: never `r_en_tot`&&`r_en_itr`; `wr_en` implies `wb_en`=7'h7F; `rd_addr` always < 4.
